// File: rtl/sine_channel_scheduler.sv
// Round-robin scheduler that time-multiplexes a dual-port sine engine across
// NUM_CH phase-accumulator channels, tracking each issued phase with a tag pipe.

module sine_tag_lane #(
    parameter int CH_W = 2,
    parameter int LAT  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic            tag_vld,
    input  logic [CH_W-1:0] tag_ch,
    input  logic [15:0]     eng_out,
    output logic            smp_valid,
    output logic [CH_W-1:0] smp_ch,
    output logic [15:0]     smp
);
    logic [LAT:0]           vld_q, vld_d;
    logic [LAT:0][CH_W-1:0] ch_q, ch_d;
    logic                   smp_valid_q, smp_valid_d;
    logic [CH_W-1:0]        smp_ch_q, smp_ch_d;
    logic [15:0]            smp_q, smp_d;

    // Stage LAT lines up with the engine output; capture it on the same step.
    always_comb begin
        vld_d       = vld_q;
        ch_d        = ch_q;
        smp_valid_d = 1'b0;
        smp_ch_d    = smp_ch_q;
        smp_d       = smp_q;
        if (adv) begin
            vld_d       = {vld_q[LAT-1:0], tag_vld};
            ch_d        = {ch_q[LAT-1:0], tag_ch};
            smp_valid_d = vld_q[LAT];
            if (vld_q[LAT]) begin
                smp_ch_d = ch_q[LAT];
                smp_d    = eng_out;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            ch_q        <= '0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_q       <= '0;
        end else begin
            vld_q       <= vld_d;
            ch_q        <= ch_d;
            smp_valid_q <= smp_valid_d;
            smp_ch_q    <= smp_ch_d;
            smp_q       <= smp_d;
        end
    end

    assign smp_valid = smp_valid_q;
    assign smp_ch    = smp_ch_q;
    assign smp       = smp_q;
endmodule

module sine_channel_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int LAT     = 3,
    parameter int PHASE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      cfg_wr,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [PHASE_W-1:0]        cfg_freq,
    input  logic                      cfg_phase_clr,
    output logic                      eng_en,
    output logic [PHASE_W-1:0]        eng_phase_a,
    output logic [PHASE_W-1:0]        eng_phase_b,
    input  logic signed [15:0]        eng_out_a,
    input  logic signed [15:0]        eng_out_b,
    output logic                      smp_valid_a,
    output logic                      smp_valid_b,
    output logic [$clog2(NUM_CH)-1:0] smp_ch_a,
    output logic [$clog2(NUM_CH)-1:0] smp_ch_b,
    output logic signed [15:0]        smp_a,
    output logic signed [15:0]        smp_b,
    output logic                      round_done,
    output logic                      busy
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int NP     = NUM_CH / 2;
    localparam int PTR_W  = (NP > 1) ? $clog2(NP) : 1;
    localparam int DCNT_W = $clog2(LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                           state_q, state_d;
    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic [DCNT_W-1:0]                dcnt_q, dcnt_d;
    logic [NUM_CH-1:0][PHASE_W-1:0]   acc_q, acc_d;
    logic [NUM_CH-1:0][PHASE_W-1:0]   freq_q, freq_d;
    logic [PHASE_W-1:0]               phase_a_q, phase_a_d, phase_b_q, phase_b_d;
    logic                             eng_en_q, eng_en_d;
    logic                             busy_q, busy_d;
    logic                             round_done_q, round_done_d;

    logic                             issue;
    logic [CH_W-1:0]                  ch_a, ch_b;
    logic [1:0]                       tag_vld;
    logic [1:0][CH_W-1:0]             tag_ch;
    logic [1:0][15:0]                 eng_out_v;
    logic [1:0]                       smp_valid_v;
    logic [1:0][CH_W-1:0]             smp_ch_v;
    logic [1:0][15:0]                 smp_v;

    // Outputs are registered from the next state, so a pair's phase is on
    // the engine port during the RUN cycle that carries its pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dcnt_d  = dcnt_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    ptr_d   = '0;
                    issue   = 1'b1;
                end
            end
            RUN: begin
                if (ptr_q == PTR_W'(NP - 1)) begin
                    ptr_d = '0;
                    if (start) begin
                        issue = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                    end
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt_q == DCNT_W'(LAT)) state_d = IDLE;
                else                         dcnt_d  = dcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ch_a = CH_W'(2 * int'(ptr_d));
    assign ch_b = ch_a + CH_W'(1);

    // Clear wins over the issue increment; a same-edge freq write only
    // affects later issues because the add reads freq_q.
    always_comb begin
        acc_d     = acc_q;
        freq_d    = freq_q;
        phase_a_d = phase_a_q;
        phase_b_d = phase_b_q;
        if (issue) begin
            phase_a_d = acc_q[ch_a];
            phase_b_d = acc_q[ch_b];
            if (ch_en[ch_a]) acc_d[ch_a] = acc_q[ch_a] + freq_q[ch_a];
            if (ch_en[ch_b]) acc_d[ch_b] = acc_q[ch_b] + freq_q[ch_b];
        end
        if (cfg_phase_clr) acc_d[cfg_ch]  = '0;
        if (cfg_wr)        freq_d[cfg_ch] = cfg_freq;
    end

    always_comb begin
        eng_en_d     = (state_d != IDLE);
        busy_d       = (state_d != IDLE);
        round_done_d = issue && (ptr_d == PTR_W'(NP - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            dcnt_q       <= '0;
            acc_q        <= '0;
            freq_q       <= '0;
            phase_a_q    <= '0;
            phase_b_q    <= '0;
            eng_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            dcnt_q       <= dcnt_d;
            acc_q        <= acc_d;
            freq_q       <= freq_d;
            phase_a_q    <= phase_a_d;
            phase_b_q    <= phase_b_d;
            eng_en_q     <= eng_en_d;
            busy_q       <= busy_d;
            round_done_q <= round_done_d;
        end
    end

    assign tag_vld   = {issue & ch_en[ch_b], issue & ch_en[ch_a]};
    assign tag_ch    = {ch_b, ch_a};
    assign eng_out_v = {eng_out_b, eng_out_a};

    // The engine advances only on enabled cycles; the issuing edge out of
    // IDLE must also load the first tag.
    for (genvar p = 0; p < 2; p++) begin : g_lane
        sine_tag_lane #(.CH_W(CH_W), .LAT(LAT)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .adv       (eng_en_q | issue),
            .tag_vld   (tag_vld[p]),
            .tag_ch    (tag_ch[p]),
            .eng_out   (eng_out_v[p]),
            .smp_valid (smp_valid_v[p]),
            .smp_ch    (smp_ch_v[p]),
            .smp       (smp_v[p])
        );
    end

    assign eng_en      = eng_en_q;
    assign busy        = busy_q;
    assign round_done  = round_done_q;
    assign eng_phase_a = phase_a_q;
    assign eng_phase_b = phase_b_q;
    assign smp_valid_a = smp_valid_v[0];
    assign smp_valid_b = smp_valid_v[1];
    assign smp_ch_a    = smp_ch_v[0];
    assign smp_ch_b    = smp_ch_v[1];
    assign smp_a       = smp_v[0];
    assign smp_b       = smp_v[1];
endmodule

// File: tb/tb_sine_channel_scheduler.sv
// Scoreboard bench: a round-level reference model queues expected samples,
// a negedge monitor pops them whenever the scheduler returns a sample.

module tb_sine_channel_scheduler;
    localparam int NUM_CH = 4;
    localparam int LAT    = 3;
    localparam int PW     = 32;
    localparam int NP     = NUM_CH / 2;
    localparam int CW     = $clog2(NUM_CH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              cfg_wr = 1'b0;
    logic [CW-1:0]     cfg_ch = '0;
    logic [PW-1:0]     cfg_freq = '0;
    logic              cfg_phase_clr = 1'b0;
    logic              eng_en, busy, round_done;
    logic [PW-1:0]     eng_phase_a, eng_phase_b;
    logic [15:0]       eng_out_a, eng_out_b;
    logic              smp_valid_a, smp_valid_b;
    logic [CW-1:0]     smp_ch_a, smp_ch_b;
    logic [15:0]       smp_a, smp_b;

    always #5 clk = ~clk;

    sine_channel_scheduler #(.NUM_CH(NUM_CH), .LAT(LAT), .PHASE_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_en(ch_en),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_freq(cfg_freq), .cfg_phase_clr(cfg_phase_clr),
        .eng_en(eng_en), .eng_phase_a(eng_phase_a), .eng_phase_b(eng_phase_b),
        .eng_out_a(eng_out_a), .eng_out_b(eng_out_b),
        .smp_valid_a(smp_valid_a), .smp_valid_b(smp_valid_b),
        .smp_ch_a(smp_ch_a), .smp_ch_b(smp_ch_b), .smp_a(smp_a), .smp_b(smp_b),
        .round_done(round_done), .busy(busy)
    );

    function automatic logic [15:0] sfun(input logic [31:0] p);
        return p[31:16] ^ p[15:0];
    endfunction

    // Stand-in sine engine: LAT enabled cycles from phase sample to output.
    logic [15:0] epa [LAT];
    logic [15:0] epb [LAT];
    always @(posedge clk) begin
        if (eng_en) begin
            epa[0] <= sfun(eng_phase_a);
            epb[0] <= sfun(eng_phase_b);
            for (int i = 1; i < LAT; i++) begin
                epa[i] <= epa[i-1];
                epb[i] <= epb[i-1];
            end
        end
    end
    assign eng_out_a = epa[LAT-1];
    assign eng_out_b = epb[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ch;
        logic [15:0] s;
        int          due;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 draining.
    int          m_mode, m_ptr, m_left;
    logic [31:0] m_acc  [NUM_CH];
    logic [31:0] m_freq [NUM_CH];
    logic        exp_en, exp_rd;
    logic [31:0] exp_pa, exp_pb;
    logic [15:0] last_a, last_b;

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_left = 0;
        for (int c = 0; c < NUM_CH; c++) begin m_acc[c] = '0; m_freq[c] = '0; end
        exp_en = 0; exp_rd = 0; exp_pa = '0; exp_pb = '0;
        last_a = '0; last_b = '0;
        qa.delete(); qb.delete();
    endtask

    // Predicts the effect of the coming clock edge from the current inputs.
    task automatic model_step();
        bit          iss;
        int          p;
        int          nmode;
        exp_t        e;
        logic [31:0] nacc [NUM_CH];
        iss = 0; p = 0; nmode = m_mode;
        if (m_mode == 0) begin
            if (start) begin nmode = 1; iss = 1; p = 0; end
        end else if (m_mode == 1) begin
            if (m_ptr < NP - 1) begin iss = 1; p = m_ptr + 1; end
            else if (start)     begin iss = 1; p = 0; end
            else                begin nmode = 2; m_left = LAT + 1; end
        end else begin
            m_left--;
            if (m_left == 0) nmode = 0;
        end
        exp_rd = 0;
        if (iss) begin
            exp_pa = m_acc[2*p];
            exp_pb = m_acc[2*p+1];
            for (int k = 0; k < 2; k++) begin
                if (ch_en[2*p+k]) begin
                    e.ch = 2*p + k; e.s = sfun(m_acc[2*p+k]); e.due = cyc + LAT + 2;
                    if (k == 0) qa.push_back(e); else qb.push_back(e);
                end
            end
            exp_rd = (p == NP - 1);
            m_ptr  = p;
        end
        for (int c = 0; c < NUM_CH; c++)
            nacc[c] = (iss && c / 2 == p && ch_en[c]) ? m_acc[c] + m_freq[c] : m_acc[c];
        if (cfg_phase_clr) nacc[cfg_ch] = '0;
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = nacc[c];
        if (cfg_wr) m_freq[cfg_ch] = cfg_freq;
        m_mode = nmode;
        exp_en = (nmode != 0);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        chk("eng_en", eng_en, exp_en);
        chk("busy", busy, exp_en);
        chk("round_done", round_done, exp_rd);
        chk("eng_phase_a", eng_phase_a, exp_pa);
        chk("eng_phase_b", eng_phase_b, exp_pb);
        cfg_wr = 1'b0;
        cfg_phase_clr = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_freq(input int ch, input logic [31:0] f);
        cfg_wr = 1'b1; cfg_ch = CW'(ch); cfg_freq = f;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_eng_en"}, eng_en, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_round_done"}, round_done, 0);
        chk({nm, "_phase_a"}, eng_phase_a, 0);
        chk({nm, "_phase_b"}, eng_phase_b, 0);
        chk({nm, "_valid_a"}, smp_valid_a, 0);
        chk({nm, "_valid_b"}, smp_valid_b, 0);
        chk({nm, "_ch_a"}, smp_ch_a, 0);
        chk({nm, "_ch_b"}, smp_ch_b, 0);
        chk({nm, "_smp_a"}, smp_a, 0);
        chk({nm, "_smp_b"}, smp_b, 0);
    endtask

    // Monitor: pops the scoreboard whenever a sample is returned.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (qa.size() > 0 && qa[0].due < cyc) begin
                e = qa.pop_front();
                chk("smp_a_missing_due", cyc, e.due);
            end
            if (qb.size() > 0 && qb[0].due < cyc) begin
                e = qb.pop_front();
                chk("smp_b_missing_due", cyc, e.due);
            end
            if (smp_valid_a) begin
                if (qa.size() == 0) chk("smp_valid_a_unexpected", smp_valid_a, 0);
                else begin
                    e = qa.pop_front();
                    chk("smp_ch_a", smp_ch_a, e.ch);
                    chk("smp_a", smp_a, e.s);
                    chk("smp_a_cycle", cyc, e.due);
                    last_a = e.s;
                end
            end else chk("smp_a_hold", smp_a, last_a);
            if (smp_valid_b) begin
                if (qb.size() == 0) chk("smp_valid_b_unexpected", smp_valid_b, 0);
                else begin
                    e = qb.pop_front();
                    chk("smp_ch_b", smp_ch_b, e.ch);
                    chk("smp_b", smp_b, e.s);
                    chk("smp_b_cycle", cyc, e.due);
                    last_b = e.s;
                end
            end else chk("smp_b_hold", smp_b, last_b);
        end
    end

    initial begin
        model_reset();
        #3;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        steps(4);

        // Basic sweep with ch0 stepping by 2^24.
        wr_freq(0, 32'h0100_0000); step();
        for (int c = 1; c < NUM_CH; c++) begin wr_freq(c, $urandom); step(); end
        ch_en = 4'b1111; start = 1'b1;
        steps(20);

        // Masking: only even channels return samples.
        ch_en = 4'b0101;
        steps(16);

        // Stop mid-round: drop start while pair 0 is on the ports.
        ch_en = 4'b1111;
        for (int i = 0; i < 8 && !(m_mode == 1 && m_ptr == 0); i++) step();
        start = 1'b0;
        steps(10);
        chk("stopped_eng_en", eng_en, 0);

        // Freq write and phase clear colliding with a ch0 issue.
        wr_freq(0, 32'h1); step();
        start = 1'b1;
        for (int i = 0; i < 8 && !(m_mode == 1 && m_ptr == NP - 1); i++) step();
        wr_freq(0, 32'h10); step();
        steps(6);
        for (int i = 0; i < 8 && !(m_mode == 1 && m_ptr == NP - 1); i++) step();
        cfg_phase_clr = 1'b1; cfg_ch = '0; step();
        steps(6);

        // Randomized traffic including config in every state.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 9) != 0) && !(i % 60 > 50);
            if ($urandom_range(0, 7) == 0) ch_en = NUM_CH'($urandom);
            if ($urandom_range(0, 5) == 0) wr_freq($urandom_range(0, NUM_CH - 1), $urandom);
            if ($urandom_range(0, 7) == 0) begin
                cfg_phase_clr = 1'b1; cfg_ch = CW'($urandom_range(0, NUM_CH - 1));
            end
            step();
        end

        // Async reset with tags in flight.
        ch_en = 4'b1111; start = 1'b1;
        steps(6);
        #2 rst = 1'b1;
        #1 chk_zero("midrun_reset");
        model_reset();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        steps(8);

        for (int i = 0; i < 100; i++) begin
            start = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 5) == 0) ch_en = NUM_CH'($urandom);
            if ($urandom_range(0, 4) == 0) wr_freq($urandom_range(0, NUM_CH - 1), $urandom);
            step();
        end
        start = 1'b0;
        steps(12);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sine_channel_scheduler.md
Name: sine_channel_scheduler

Overview:
Time-multiplexes the dual-port quarter-wave sine engine among NUM_CH independent oscillator channels. Each channel owns a phase accumulator and a frequency word. The scheduler issues one channel phase per engine port per cycle in fixed round-robin pairs. It tracks each issued phase through the engine latency with a tag pipeline and returns tagged samples. It sits between the register/config interface and the sine engine, and drives the engine's enable.

Parameters:
NUM_CH, 4, channel count; even, 2..16
LAT, 3, engine latency in enabled cycles from phase sampled to output valid
PHASE_W, 32, phase accumulator / frequency word width

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; run rounds while high
ch_en  in  NUM_CH  per-channel enable, sampled at each issue
cfg_wr  in  1  write pulse for frequency word
cfg_ch  in  clog2(NUM_CH)  target channel for cfg_wr / cfg_phase_clr
cfg_freq  in  PHASE_W  frequency (phase increment) word
cfg_phase_clr  in  1  pulse; zero target channel accumulator
eng_en  out  1  engine step enable
eng_phase_a  out  PHASE_W  phase to engine port A
eng_phase_b  out  PHASE_W  phase to engine port B
eng_out_a  in  16 signed  engine port A sample
eng_out_b  in  16 signed  engine port B sample
smp_valid_a / smp_valid_b  out  1  sample valid strobe per port
smp_ch_a / smp_ch_b  out  clog2(NUM_CH)  channel of returned sample
smp_a / smp_b  out  16 signed  returned sample
round_done  out  1  one-cycle pulse on issue of last pair in a round
busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; accumulators, freq words, pair pointer, drain counter and tag pipeline cleared. Reset mid-RUN/DRAIN discards all in-flight tags; no smp_valid after release until new issues complete.
- FSM: IDLE -> RUN when start=1 (pointer=0). RUN -> DRAIN on the cycle the last pair (pointer=NUM_CH/2-1) is issued with start=0; the round always completes. DRAIN -> IDLE after LAT+1 cycles. DRAIN with start=1 still completes to IDLE first. IDLE -> RUN may occur in the next cycle.
- eng_en = 1 in RUN and DRAIN, 0 in IDLE. busy mirrors this.
- Issue (RUN, pointer p): port A gets ch 2p and port B gets ch 2p+1.
  - eng_phase_* are registered and hold the current accumulator value, pre-increment.
  - Pointer wraps to 0 after NUM_CH/2-1. round_done pulses in the same cycle as that issue.
- Accumulator update: on issue of an enabled channel, acc <= acc + freq, modulo 2^PHASE_W with silent wrap.
  - Disabled channel: phase still driven, acc held, tag invalid.
- Tags: {valid, ch} per port, LAT+1-stage shift register advanced every eng_en cycle.
  - For a phase driven in cycle k, smp_valid_*, smp_ch_* and smp_* (registered from eng_out_*) appear in cycle k+LAT+1, for one cycle.
  - smp_* hold their last value when valid=0.
- In DRAIN, eng_phase_* hold their last values and invalid tags are inserted.
- cfg_wr: freq[cfg_ch] <= cfg_freq next edge.
  - If the same channel is issued in the same cycle, the add uses the old freq; the new value applies from the next issue.
- cfg_phase_clr: acc[cfg_ch] <= 0. Has priority over a simultaneous issue increment; the phase issued that cycle is the pre-clear value.
- Both cfg_wr and cfg_phase_clr may occur in any state, including IDLE.
- start toggling mid-round has no effect until the round boundary.

Test Plan:
- Reset: with rst=1, every output is 0. After release, with start=0, eng_en stays 0 and no smp_valid occurs.
- Basic sweep: NUM_CH=4, LAT=3, ch_en=4'b1111, freq[0]=0x0100_0000, start held high.
  - ch0 phases issue on port A as 0x0, 0x0100_0000, 0x0200_0000, … every 2 cycles.
  - smp_valid_a with smp_ch_a=0 appears 4 cycles after each ch0 issue.
  - round_done pulses every 2nd cycle.
- Masking: ch_en=4'b0101.
  - Only ch0 (A) and ch2 (A) return valid samples; smp_valid_b is never asserted.
  - acc[1] and acc[3] stay constant.
- Stop mid-round: drop start while pointer=0.
  - Pair 1 still issues; 4 drain cycles follow; eng_en=0 and busy=0 after.
  - Last smp_valid occurs in the final drain cycle.
- Config collision: cfg_wr ch0 freq=0x10 in the same cycle ch0 issues with old freq 0x1.
  - Next ch0 phase = old+0x1; the following phase = +0x10.
  - cfg_phase_clr in the same cycle as an issue yields acc=0, not 0+freq.
- Async reset during RUN with tags in flight: outputs clear immediately, and no stale smp_valid appears after release.
